// File: rtl/rect_unit.sv
// rect_unit: streams a W x H rectangle as row-major pixel writes with
// (delta_x, delta_y) offsets from the caller's origin. Supports solid fill,
// outline-only, outline on a background interior, and dashed rows. Honours
// downstream back-pressure (wr_ready) and abort. A start/done handshake
// connects it to the command decoder.
module rect_unit #(
  parameter int COORD_W = 12,
  parameter int PIX_W   = 4,
  parameter int DASH_W  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  input  logic [1:0]         mode,
  input  logic [PIX_W-1:0]   fg_color,
  input  logic [PIX_W-1:0]   bg_color,
  input  logic [DASH_W-1:0]  dash_len,
  output logic [PIX_W-1:0]   pix_out,
  output logic [COORD_W-1:0] delta_x,
  output logic [COORD_W-1:0] delta_y,
  output logic               wr,
  input  logic               wr_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DRAW = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    M_FILL  = 2'b00,
    M_OSKIP = 2'b01,
    M_OBG   = 2'b10,
    M_DASH  = 2'b11
  } mode_t;

  // Control state and the parameters latched at start.
  state_t             r_state;
  mode_t              r_mode;
  logic [COORD_W-1:0] r_w;
  logic [COORD_W-1:0] r_h;
  logic [PIX_W-1:0]   r_fg;
  logic [PIX_W-1:0]   r_bg;
  logic [DASH_W-1:0]  r_dash;

  // Drawing position and dash phase within the current row.
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [DASH_W-1:0]  r_phase;
  logic               r_dash_bg;

  // Position decode derived purely from registered state.
  logic               w_x_last;
  logic               w_y_last;
  logic               w_is_edge;
  logic               w_skip_row;
  logic               w_dash_wrap;
  logic [COORD_W-1:0] w_x_next;
  logic [PIX_W-1:0]   w_pix;
  logic               w_drawing;

  assign w_drawing   = (r_state == S_DRAW);
  assign w_x_last    = (r_x == r_w - COORD_W'(1));
  assign w_y_last    = (r_y == r_h - COORD_W'(1));
  assign w_is_edge   = (r_x == '0) || (r_y == '0) || w_x_last || w_y_last;
  assign w_dash_wrap = (r_phase == r_dash - DASH_W'(1));

  // Interior rows of an outline-skip draw only visit the two edge columns.
  assign w_skip_row  = (r_mode == M_OSKIP) && (r_y != '0) && !w_y_last &&
                       (r_w > COORD_W'(2));

  assign w_x_next    = (w_skip_row && (r_x == '0)) ? (r_w - COORD_W'(1))
                                                   : (r_x + COORD_W'(1));

  // Colour of the pixel currently presented, chosen by the latched mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_pix = '0;
    if (w_drawing) begin
      case (r_mode)
        M_FILL:  w_pix = r_fg;
        M_OSKIP: w_pix = r_fg;
        M_OBG:   w_pix = w_is_edge ? r_fg : r_bg;
        M_DASH:  w_pix = r_dash_bg ? r_bg : r_fg;
        default: w_pix = '0;
      endcase
    end
  end

  // Outputs depend only on registered state, never on wr_ready or abort.
  assign wr      = w_drawing;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign pix_out = w_pix;
  assign delta_x = w_drawing ? r_x : '0;
  assign delta_y = w_drawing ? r_y : '0;

  // Control FSM: latches the request, walks the rectangle, pulses done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      r_state   <= S_IDLE;
      r_mode    <= M_FILL;
      r_w       <= '0;
      r_h       <= '0;
      r_fg      <= '0;
      r_bg      <= '0;
      r_dash    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_phase   <= '0;
      r_dash_bg <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode    <= mode_t'(mode);
            r_w       <= width;
            r_h       <= height;
            r_fg      <= fg_color;
            r_bg      <= bg_color;
            r_dash    <= (dash_len == '0) ? DASH_W'(1) : dash_len;
            r_x       <= '0;
            r_y       <= '0;
            r_phase   <= '0;
            r_dash_bg <= 1'b0;
            if ((width == '0) || (height == '0)) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_DRAW;
            end
          end
        end

        S_DRAW: begin
          if (abort) begin
            r_state <= S_DONE;
          end else if (wr_ready) begin
            if (w_x_last && w_y_last) begin
              r_state <= S_DONE;
            end else if (w_x_last) begin
              r_x       <= '0;
              r_y       <= r_y + COORD_W'(1);
              r_phase   <= '0;
              r_dash_bg <= 1'b0;
            end else begin
              r_x <= w_x_next;
              if (w_dash_wrap) begin
                r_phase   <= '0;
                r_dash_bg <= ~r_dash_bg;
              end else begin
                r_phase <= r_phase + DASH_W'(1);
              end
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_unit.sv
// Self-checking bench for rect_unit: directed table of draws, hand-written
// stall/abort/reset sequences, and randomized draws against a reference
// model that enumerates the expected pixel list directly from the drawing
// rules.
module tb_rect_unit;

  localparam int CW = 12;
  localparam int PW = 4;
  localparam int DW = 4;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          wr_ready = 1'b0;
  logic [CW-1:0] width = '0;
  logic [CW-1:0] height = '0;
  logic [1:0]    mode = '0;
  logic [PW-1:0] fg_color = '0;
  logic [PW-1:0] bg_color = '0;
  logic [DW-1:0] dash_len = '0;
  logic [PW-1:0] pix_out;
  logic [CW-1:0] delta_x;
  logic [CW-1:0] delta_y;
  logic          wr;
  logic          busy;
  logic          done;

  rect_unit #(.COORD_W(CW), .PIX_W(PW), .DASH_W(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .width    (width),
    .height   (height),
    .mode     (mode),
    .fg_color (fg_color),
    .bg_color (bg_color),
    .dash_len (dash_len),
    .pix_out  (pix_out),
    .delta_x  (delta_x),
    .delta_y  (delta_y),
    .wr       (wr),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [PW-1:0] p;
  } pix_t;

  typedef struct {
    int         w;
    int         h;
    logic [1:0] m;
    logic [3:0] fg;
    logic [3:0] bg;
    int         dash;
    int         exp_n;
    int         exp_done;
  } vec_t;

  pix_t exp_q[$];
  pix_t got_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_done_cyc;
  int   last_xfer_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: list every pixel the rectangle should produce.
  task automatic build_model(input int w, input int h, input logic [1:0] m,
                             input logic [PW-1:0] fg, input logic [PW-1:0] bg,
                             input int dash);
    int   d;
    bit   is_edge;
    pix_t e;
    d = (dash == 0) ? 1 : dash;
    exp_q.delete();
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        is_edge = (yy == 0) || (yy == h - 1) || (xx == 0) || (xx == w - 1);
        e.x = xx[CW-1:0];
        e.y = yy[CW-1:0];
        case (m)
          2'b00: begin e.p = fg; exp_q.push_back(e); end
          2'b01: if (is_edge) begin e.p = fg; exp_q.push_back(e); end
          2'b10: begin e.p = is_edge ? fg : bg; exp_q.push_back(e); end
          default: begin e.p = (((xx / d) % 2) == 1) ? bg : fg; exp_q.push_back(e); end
        endcase
      end
    end
  endtask

  // Issue one draw, collect transfers, and compare against the model.
  task automatic run_draw(input string tag, input int w, input int h,
                          input logic [1:0] m, input logic [PW-1:0] fg,
                          input logic [PW-1:0] bg, input int dash,
                          input int ready_pct, input int stall_cyc,
                          input int stall_len, input int abort_cyc,
                          input int restart_cyc);
    bit   seen_done;
    bit   stall;
    pix_t prev;
    int   n;
    build_model(w, h, m, fg, bg, dash);
    if (abort_cyc > 0) begin
      while (exp_q.size() > abort_cyc) void'(exp_q.pop_back());
    end
    got_q.delete();
    seen_done = 0;
    stall = 0;
    prev = '0;
    last_done_cyc = 0;
    last_xfer_cyc = 0;
    @(posedge clk); #1;
    width = w[CW-1:0]; height = h[CW-1:0]; mode = m;
    fg_color = fg; bg_color = bg; dash_len = dash[DW-1:0];
    start = 1'b1; abort = 1'b0;
    for (int cyc = 1; cyc <= BUDGET && !seen_done; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == restart_cyc);
      abort = (cyc == abort_cyc);
      if (cyc >= stall_cyc && cyc < stall_cyc + stall_len) wr_ready = 1'b0;
      else wr_ready = ($urandom_range(99) < ready_pct);
      // Scramble request inputs: the draw must use the latched copies.
      width = CW'($urandom); height = CW'($urandom); mode = 2'($urandom);
      fg_color = PW'($urandom); bg_color = PW'($urandom); dash_len = DW'($urandom);
      @(negedge clk);
      if (stall) check({tag, " stall hold"}, {wr, delta_x, delta_y, pix_out},
                       {1'b1, prev.x, prev.y, prev.p});
      if (wr) begin
        prev.x = delta_x; prev.y = delta_y; prev.p = pix_out;
        stall = !wr_ready;
        if (wr_ready) begin
          got_q.push_back(prev);
          last_xfer_cyc = cyc;
        end
      end else begin
        stall = 0;
      end
      if (done) begin
        seen_done = 1;
        last_done_cyc = cyc;
      end
    end
    check({tag, " done seen"}, seen_done, 1);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check({tag, " done single cycle"}, {done, busy}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " idle after done"}, {wr, busy}, 2'b00);
    check({tag, " transfer count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, " pixel"}, got_q[i], exp_q[i]);
    if (got_q.size() > 0) check({tag, " done latency"}, last_done_cyc, last_xfer_cyc + 1);
    else check({tag, " empty done"}, last_done_cyc, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl[11];
  logic [PW-1:0] dash_pat[10];

  initial begin
    tbl[0]  = '{3, 2, 2'b00, 4'h5, 4'h0, 0, 6, 7};
    tbl[1]  = '{4, 3, 2'b01, 4'h9, 4'h0, 0, 10, 11};
    tbl[2]  = '{4, 3, 2'b10, 4'h9, 4'h6, 0, 12, 13};
    tbl[3]  = '{10, 1, 2'b11, 4'hF, 4'h2, 3, 10, 11};
    tbl[4]  = '{4, 1, 2'b11, 4'h3, 4'hC, 0, 4, 5};
    tbl[5]  = '{0, 5, 2'b00, 4'h1, 4'h0, 0, 0, 1};
    tbl[6]  = '{4, 0, 2'b10, 4'h1, 4'h2, 0, 0, 1};
    tbl[7]  = '{1, 3, 2'b01, 4'h7, 4'h0, 0, 3, 4};
    tbl[8]  = '{2, 3, 2'b01, 4'h8, 4'h0, 0, 6, 7};
    tbl[9]  = '{5, 1, 2'b01, 4'hB, 4'h0, 0, 5, 6};
    tbl[10] = '{3, 3, 2'b01, 4'hD, 4'h0, 0, 8, 9};
    dash_pat = '{4'hF, 4'hF, 4'hF, 4'h2, 4'h2, 4'h2, 4'hF, 4'hF, 4'hF, 4'h2};

    // Reset state.
    #2;
    check("reset outputs", {wr, busy, done, pix_out, delta_x, delta_y}, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle after reset", {wr, busy, done}, 3'b000);

    // Directed table; a start during the draw must be ignored.
    for (int i = 0; i < 11; i++) begin
      run_draw($sformatf("tbl%0d", i), tbl[i].w, tbl[i].h, tbl[i].m, tbl[i].fg,
               tbl[i].bg, tbl[i].dash, 100, 0, 0, 0, (tbl[i].exp_n > 0) ? 2 : 1);
      check($sformatf("tbl%0d writes", i), got_q.size(), tbl[i].exp_n);
      check($sformatf("tbl%0d done cycle", i), last_done_cyc, tbl[i].exp_done);
    end

    // Dashed row with explicit colour pattern under random back-pressure.
    run_draw("dash10", 10, 1, 2'b11, 4'hF, 4'h2, 3, 60, 0, 0, 0, 0);
    for (int i = 0; i < 10 && i < got_q.size(); i++)
      check($sformatf("dash10 colour x%0d", i), got_q[i].p, dash_pat[i]);

    // Outline-skip row 1 visits x=0 then x=3 on consecutive writes.
    run_draw("oskip43", 4, 3, 2'b01, 4'h9, 4'h0, 0, 100, 0, 0, 0, 0);
    if (got_q.size() >= 6) begin
      check("oskip43 row1 first", {got_q[4].x, got_q[4].y}, {12'd0, 12'd1});
      check("oskip43 row1 second", {got_q[5].x, got_q[5].y}, {12'd3, 12'd1});
    end else check("oskip43 size", got_q.size(), 10);

    // Outline-bg interior pixels.
    run_draw("obg43", 4, 3, 2'b10, 4'h9, 4'h6, 0, 100, 0, 0, 0, 0);
    if (got_q.size() >= 7) begin
      check("obg43 (1,1)", {got_q[5].x, got_q[5].y, got_q[5].p}, {12'd1, 12'd1, 4'h6});
      check("obg43 (2,1)", {got_q[6].x, got_q[6].y, got_q[6].p}, {12'd2, 12'd1, 4'h6});
    end else check("obg43 size", got_q.size(), 12);

    // Back-pressure: wr_ready low for 3 cycles while (1,0) is presented.
    run_draw("stall22", 2, 2, 2'b00, 4'h4, 4'h0, 0, 100, 2, 3, 0, 0);
    check("stall22 writes", got_q.size(), 4);
    check("stall22 done cycle", last_done_cyc, 8);

    // Abort while (2,1) of a 5x3 fill is presented.
    run_draw("abort53", 5, 3, 2'b00, 4'hE, 4'h0, 0, 100, 0, 0, 8, 0);
    check("abort53 writes", got_q.size(), 8);
    check("abort53 done cycle", last_done_cyc, 9);

    // Asynchronous reset mid-draw.
    @(posedge clk); #1;
    width = 12'd5; height = 12'd3; mode = 2'b00; fg_color = 4'hA;
    start = 1'b1; wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre-reset drawing", {wr, busy}, 2'b11);
    reset_n = 1'b0;
    #1;
    check("reset async outputs", {wr, busy, done, pix_out, delta_x, delta_y}, '0);
    repeat (3) begin
      @(negedge clk);
      check("reset held quiet", {wr, busy, done}, 3'b000);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no done after reset", {wr, busy, done}, 3'b000);
    end

    // Randomized draws against the model.
    for (int i = 0; i < 40; i++) begin
      run_draw($sformatf("rnd%0d", i), $urandom_range(0, 9), $urandom_range(0, 6),
               2'($urandom_range(0, 3)), PW'($urandom), PW'($urandom),
               $urandom_range(0, 5), 60, 0, 0, 0, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
